// File: rtl/writeback_stage.sv
// writeback_stage: final RV32I pipeline stage and the only writer of the
// register file's write port.
//
// The stage accepts one retiring instruction per valid/ready handshake. For a
// load it waits for the data-memory response, then aligns the data and sign- or
// zero-extends it. Every instruction produces exactly one commit cycle. In that
// cycle write_enable may pulse for one cycle, and retired_count advances by one.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            handshake with the MEM stage
//   in_rd, in_wb_sel, in_alu_result, in_pc, in_funct3, in_addr_lo
//                                  instruction fields from the MEM stage
//   mem_rvalid, mem_rdata          data-memory load response
//   write_reg, write_enable, write_data
//                                  register-file write port (registered)
//   load_err                       one-cycle pulse for a misaligned or illegal load
//   retired_count                  instructions committed since reset
//
// State | meaning
// IDLE     | nothing in flight, ready for a new instruction
// WAIT_MEM | load accepted, waiting for mem_rvalid
// COMMIT   | write-port outputs valid this cycle, can accept the next instruction
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [4:0]       write_reg,
    output logic             write_enable,
    output logic [XLEN-1:0]  write_data,
    output logic             load_err,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

    state_t state, state_nxt;

    logic [4:0] lat_rd, lat_rd_nxt;
    logic [2:0] lat_funct3, lat_funct3_nxt;
    logic [1:0] lat_addr_lo, lat_addr_lo_nxt;

    logic [4:0]       wreg_nxt;
    logic             we_nxt;
    logic [XLEN-1:0]  wdata_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic            ld_err;
    logic            accept;

    assign in_ready = (state != WAIT_MEM);
    assign accept   = in_valid && in_ready;

    // Load alignment works on the latched size/offset and the live memory word.
    always_comb begin
        ld_byte = mem_rdata[8*lat_addr_lo +: 8];
        ld_half = lat_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = '0;
        ld_err  = 1'b0;
        case (lat_funct3)
            3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_err  = lat_addr_lo[0];
            end
            3'b101: begin
                ld_data = {{(XLEN-16){1'b0}}, ld_half};
                ld_err  = lat_addr_lo[0];
            end
            3'b010: begin
                ld_data = mem_rdata;
                ld_err  = (lat_addr_lo != 2'b00);
            end
            default: ld_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        lat_rd_nxt      = lat_rd;
        lat_funct3_nxt  = lat_funct3;
        lat_addr_lo_nxt = lat_addr_lo;
        wreg_nxt        = write_reg;
        wdata_nxt       = write_data;
        we_nxt          = 1'b0;
        err_nxt         = 1'b0;
        cnt_nxt         = retired_count;

        case (state)
            IDLE, COMMIT: begin
                if (accept) begin
                    lat_rd_nxt      = in_rd;
                    lat_funct3_nxt  = in_funct3;
                    lat_addr_lo_nxt = in_addr_lo;
                    if (in_wb_sel == SEL_LOAD) begin
                        state_nxt = WAIT_MEM;
                    end else begin
                        // Non-loads commit straight from the accept edge.
                        state_nxt = COMMIT;
                        wreg_nxt  = in_rd;
                        case (in_wb_sel)
                            SEL_ALU: wdata_nxt = in_alu_result;
                            SEL_PC4: wdata_nxt = in_pc + XLEN'(4);
                            default: wdata_nxt = '0;
                        endcase
                        we_nxt  = (in_rd != 5'd0) && (in_wb_sel != 2'b11);
                        cnt_nxt = retired_count + CNT_W'(1);
                    end
                end else if (state == COMMIT) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_nxt = COMMIT;
                    wreg_nxt  = lat_rd;
                    wdata_nxt = ld_err ? '0 : ld_data;
                    we_nxt    = !ld_err && (lat_rd != 5'd0);
                    err_nxt   = ld_err;
                    cnt_nxt   = retired_count + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lat_rd        <= '0;
            lat_funct3    <= '0;
            lat_addr_lo   <= '0;
            write_reg     <= '0;
            write_enable  <= 1'b0;
            write_data    <= '0;
            load_err      <= 1'b0;
            retired_count <= '0;
        end else begin
            state         <= state_nxt;
            lat_rd        <= lat_rd_nxt;
            lat_funct3    <= lat_funct3_nxt;
            lat_addr_lo   <= lat_addr_lo_nxt;
            write_reg     <= wreg_nxt;
            write_enable  <= we_nxt;
            write_data    <= wdata_nxt;
            load_err      <= err_nxt;
            retired_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc = '0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  write_reg;
    logic        write_enable;
    logic [31:0] write_data;
    logic        load_err;
    logic [31:0] retired_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt = '0;

    writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc(in_pc),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write_reg(write_reg), .write_enable(write_enable),
        .write_data(write_data), .load_err(load_err),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction offer; it is taken at the next rising edge.
    task automatic offer(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] alo);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc         = pc;
        in_funct3     = f3;
        in_addr_lo    = alo;
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_reg", 32'(write_reg), 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_cnt", retired_count, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        step; step;
        rst_n = 1'b1;
        step;

        // 1: ALU write, single pulse.
        offer(5'd1, 2'b00, 32'hAABBCCDD, 32'h0, 3'b000, 2'b00);
        step;
        in_valid = 1'b0;
        exp_cnt++;
        check("alu_we", 32'(write_enable), 32'd1);
        check("alu_reg", 32'(write_reg), 32'd1);
        check("alu_data", write_data, 32'hAABBCCDD);
        check("alu_cnt", retired_count, exp_cnt);
        step;
        check("alu_we_off", 32'(write_enable), 32'd0);
        check("alu_hold_data", write_data, 32'hAABBCCDD);

        // 2: LB at byte 2, response 3 cycles later; rvalid in accept cycle ignored.
        offer(5'd2, 2'b01, 32'h0, 32'h0, 3'b000, 2'b10);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0000;
        step;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("lb_wait_ready", 32'(in_ready), 32'd0);
            check("lb_wait_we", 32'(write_enable), 32'd0);
            step;
        end
        check("lb_wait_ready2", 32'(in_ready), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12F45678;
        step;
        mem_rvalid = 1'b0;
        exp_cnt++;
        check("lb_we", 32'(write_enable), 32'd1);
        check("lb_reg", 32'(write_reg), 32'd2);
        check("lb_data", write_data, 32'hFFFFFFF4);
        check("lb_cnt", retired_count, exp_cnt);
        check("lb_ready", 32'(in_ready), 32'd1);
        step;

        // 3: LHU upper half, then misaligned LH.
        offer(5'd3, 2'b01, 32'h0, 32'h0, 3'b101, 2'b10);
        step;
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80010000;
        step;
        mem_rvalid = 1'b0;
        exp_cnt++;
        check("lhu_we", 32'(write_enable), 32'd1);
        check("lhu_data", write_data, 32'h00008001);

        offer(5'd4, 2'b01, 32'h0, 32'h0, 3'b001, 2'b01);
        step;
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        step;
        mem_rvalid = 1'b0;
        exp_cnt++;
        check("lh_err", 32'(load_err), 32'd1);
        check("lh_err_we", 32'(write_enable), 32'd0);
        check("lh_err_data", write_data, 32'd0);
        check("lh_err_cnt", retired_count, exp_cnt);
        step;
        check("lh_err_off", 32'(load_err), 32'd0);

        // 4: PC+4 wraps, then three back-to-back ALU ops.
        offer(5'd5, 2'b10, 32'h0, 32'hFFFFFFFC, 3'b000, 2'b00);
        step;
        in_valid = 1'b0;
        exp_cnt++;
        check("pc4_we", 32'(write_enable), 32'd1);
        check("pc4_reg", 32'(write_reg), 32'd5);
        check("pc4_data", write_data, 32'h00000000);
        step;
        for (int i = 0; i < 3; i++) begin
            offer(5'(6 + i), 2'b00, 32'(100 + i), 32'h0, 3'b000, 2'b00);
            step;
            exp_cnt++;
            check("b2b_we", 32'(write_enable), 32'd1);
            check("b2b_reg", 32'(write_reg), 32'(6 + i));
            check("b2b_data", write_data, 32'(100 + i));
        end
        in_valid = 1'b0;
        check("b2b_cnt", retired_count, exp_cnt);
        step;
        check("b2b_we_off", 32'(write_enable), 32'd0);

        // 5: rd=0 never writes but still retires.
        offer(5'd0, 2'b00, 32'hABCDEFFF, 32'h0, 3'b000, 2'b00);
        step;
        in_valid = 1'b0;
        exp_cnt++;
        check("x0_we", 32'(write_enable), 32'd0);
        check("x0_reg", 32'(write_reg), 32'd0);
        check("x0_cnt", retired_count, exp_cnt);
        step;
        check("x0_we2", 32'(write_enable), 32'd0);

        // wb_sel NONE: no write, data 0, still retires.
        offer(5'd9, 2'b11, 32'h12345678, 32'h0, 3'b000, 2'b00);
        step;
        in_valid = 1'b0;
        exp_cnt++;
        check("none_we", 32'(write_enable), 32'd0);
        check("none_reg", 32'(write_reg), 32'd9);
        check("none_data", write_data, 32'd0);
        check("none_cnt", retired_count, exp_cnt);
        step;

        // 6: async reset during WAIT_MEM drops the load.
        offer(5'd10, 2'b01, 32'h0, 32'h0, 3'b010, 2'b00);
        step;
        in_valid = 1'b0;
        step;
        check("pre_rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_cnt", retired_count, 32'd0);
        check("mid_rst_reg", 32'(write_reg), 32'd0);
        check("mid_rst_data", write_data, 32'd0);
        step;
        rst_n = 1'b1;
        step;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        step;
        mem_rvalid = 1'b0;
        check("late_rvalid_we", 32'(write_enable), 32'd0);
        check("late_rvalid_cnt", retired_count, 32'd0);
        check("late_rvalid_data", write_data, 32'd0);
        step;
        check("late_rvalid_we2", 32'(write_enable), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
